// File: rtl/hrg_io_writer_if.sv
// Bundle of the CPU I/O, display-port and video-memory signals of hrg_io_writer.
// The slave modport is the block itself; master is whoever drives the CPU/arbiter side.
interface hrg_io_writer_if;
    logic        i_io_wr;
    logic        i_io_rd;
    logic [7:0]  i_io_addr;
    logic [7:0]  i_io_data;
    logic [7:0]  o_io_data;
    logic        o_io_data_valid;
    logic        o_io_wait;
    logic [7:0]  o_hrg_port0;
    logic        o_hrg_port0_valid;
    logic [7:0]  o_hrg_port1;
    logic        o_hrg_port1_valid;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [13:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;

    modport slave (
        input  i_io_wr, i_io_rd, i_io_addr, i_io_data, i_mem_gnt, i_mem_rdata,
        output o_io_data, o_io_data_valid, o_io_wait,
        output o_hrg_port0, o_hrg_port0_valid, o_hrg_port1, o_hrg_port1_valid,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_io_wr, i_io_rd, i_io_addr, i_io_data, i_mem_gnt, i_mem_rdata,
        input  o_io_data, o_io_data_valid, o_io_wait,
        input  o_hrg_port0, o_hrg_port0_valid, o_hrg_port1, o_hrg_port1_valid,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/hrg_io_writer.sv
// HRG I/O port decoder: regenerates the display port strobes and gives the CPU
// buffered writes and blocking, write-coherent reads into HRG video memory.
module hrg_io_writer #(
    parameter logic [7:0] BASE_PORT  = 8'h04,
    parameter int         ADDR_MAX   = 15359,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    hrg_io_writer_if.slave bus
);
    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [13:0]      LAST_ADDR = 14'(ADDR_MAX);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       port0_q, port0_d;
    logic             port0_valid_q, port0_valid_d;
    logic [7:0]       port1_q, port1_d;
    logic             port1_valid_q, port1_valid_d;
    logic [13:0]      addr_q, addr_d;
    logic [13:0]      rd_addr_q, rd_addr_d;
    logic             rd_pending_q, rd_pending_d;
    logic [7:0]       io_data_q, io_data_d;
    logic             io_data_valid_q, io_data_valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [13:0]      fifo_addr_mem [FIFO_DEPTH];
    logic [7:0]       fifo_data_mem [FIFO_DEPTH];

    logic [7:0]       off;
    logic             fifo_empty, fifo_full;
    logic             io_wait, wr_acc, rd_acc, push, pop;
    logic [13:0]      addr_inc;
    logic             mem_req, mem_we;
    logic [13:0]      mem_addr;
    logic [7:0]       mem_wdata;

    always_comb begin
        off        = bus.i_io_addr - BASE_PORT;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // A data read waits until every queued write has reached memory.
        io_wait    = (bus.i_io_wr && off == 8'd4 && fifo_full) || rd_pending_q ||
                     (bus.i_io_rd && off == 8'd5 && !fifo_empty);
        wr_acc     = bus.i_io_wr && !io_wait;
        rd_acc     = bus.i_io_rd && !bus.i_io_wr && !io_wait;
        push       = wr_acc && off == 8'd4;
        addr_inc   = (addr_q == LAST_ADDR) ? 14'd0 : addr_q + 14'd1;
    end

    always_comb begin
        port0_d         = port0_q;
        port0_valid_d   = 1'b0;
        port1_d         = port1_q;
        port1_valid_d   = 1'b0;
        addr_d          = addr_q;
        rd_addr_d       = rd_addr_q;
        rd_pending_d    = rd_pending_q;
        io_data_d       = io_data_q;
        io_data_valid_d = 1'b0;
        if (wr_acc) begin
            case (off)
                8'd0: begin port0_d = bus.i_io_data; port0_valid_d = 1'b1; end
                8'd1: begin port1_d = bus.i_io_data; port1_valid_d = 1'b1; end
                8'd2: addr_d[7:0]  = bus.i_io_data;
                8'd3: addr_d[13:8] = bus.i_io_data[5:0];
                8'd4: addr_d = addr_inc;
                default: ;
            endcase
        end else if (rd_acc) begin
            case (off)
                8'd0: begin io_data_d = port0_q;                io_data_valid_d = 1'b1; end
                8'd1: begin io_data_d = port1_q;                io_data_valid_d = 1'b1; end
                8'd2: begin io_data_d = addr_q[7:0];            io_data_valid_d = 1'b1; end
                8'd3: begin io_data_d = {2'b00, addr_q[13:8]};  io_data_valid_d = 1'b1; end
                8'd4: begin io_data_d = 8'hFF;                  io_data_valid_d = 1'b1; end
                8'd5: begin
                    rd_addr_d    = addr_q;
                    addr_d       = addr_inc;
                    rd_pending_d = 1'b1;
                end
                default: ;
            endcase
        end
        if (state_q == S_RD_WAIT) begin
            io_data_d       = bus.i_mem_rdata;
            io_data_valid_d = 1'b1;
            rd_pending_d    = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty)       state_d = S_WRITE;
                else if (rd_pending_q) state_d = S_RD_REQ;
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr_mem[rd_ptr_q];
                mem_wdata = fifo_data_mem[rd_ptr_q];
                if (bus.i_mem_gnt) begin
                    pop = 1'b1;
                    // A push landing on the last pop keeps us writing.
                    if (count_q == CNT_W'(1) && !push)
                        state_d = rd_pending_q ? S_RD_REQ : S_IDLE;
                end
            end
            S_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = rd_addr_q;
                if (bus.i_mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
        count_d  = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= addr_q;
            fifo_data_mem[wr_ptr_q] <= bus.i_io_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= S_IDLE;
            port0_q         <= '0;
            port0_valid_q   <= 1'b0;
            port1_q         <= '0;
            port1_valid_q   <= 1'b0;
            addr_q          <= '0;
            rd_addr_q       <= '0;
            rd_pending_q    <= 1'b0;
            io_data_q       <= '0;
            io_data_valid_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            port0_q         <= port0_d;
            port0_valid_q   <= port0_valid_d;
            port1_q         <= port1_d;
            port1_valid_q   <= port1_valid_d;
            addr_q          <= addr_d;
            rd_addr_q       <= rd_addr_d;
            rd_pending_q    <= rd_pending_d;
            io_data_q       <= io_data_d;
            io_data_valid_q <= io_data_valid_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    assign bus.o_io_data         = io_data_q;
    assign bus.o_io_data_valid   = io_data_valid_q;
    assign bus.o_io_wait         = io_wait;
    assign bus.o_hrg_port0       = port0_q;
    assign bus.o_hrg_port0_valid = port0_valid_q;
    assign bus.o_hrg_port1       = port1_q;
    assign bus.o_hrg_port1_valid = port1_valid_q;
    assign bus.o_mem_req         = mem_req;
    assign bus.o_mem_we          = mem_we;
    assign bus.o_mem_addr        = mem_addr;
    assign bus.o_mem_wdata       = mem_wdata;
endmodule

// File: tb/tb_hrg_io_writer.sv
// Directed bench for hrg_io_writer: a register/queue model predicts every strobe,
// read and memory write; literal checks pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_hrg_io_writer;
    localparam logic [7:0] BASE = 8'h04;
    localparam int         AMAX = 15359;

    typedef struct packed { logic [13:0] a; logic [7:0] d; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hrg_io_writer_if bus();
    hrg_io_writer #(.BASE_PORT(BASE), .ADDR_MAX(AMAX), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [13:0] m_addr;
    logic [7:0]  m_port0, m_port1;
    logic [7:0]  model_mem [16384];
    logic [7:0]  ram [16384];
    wr_t         exp_wr[$];
    wr_t         mem_log[$];
    logic [7:0]  exp_p0[$], exp_p1[$], exp_rd[$];
    logic [13:0] exp_rd_addr[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [13:0] next_addr(input logic [13:0] a);
        int n;
        n = (int'(a) == AMAX) ? 0 : (int'(a) + 1) % 16384;
        return n[13:0];
    endfunction

    function automatic logic [7:0] mem_view(input logic [13:0] a);
        logic [7:0] v;
        v = model_mem[a];
        foreach (exp_wr[i]) if (exp_wr[i].a == a) v = exp_wr[i].d;
        return v;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] o;
        o = a - BASE;
        case (o)
            8'd0: begin m_port0 = d; exp_p0.push_back(d); end
            8'd1: begin m_port1 = d; exp_p1.push_back(d); end
            8'd2: m_addr[7:0]  = d;
            8'd3: m_addr[13:8] = d[5:0];
            8'd4: begin exp_wr.push_back('{a: m_addr, d: d}); m_addr = next_addr(m_addr); end
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [7:0] a);
        logic [7:0] o;
        o = a - BASE;
        case (o)
            8'd0: exp_rd.push_back(m_port0);
            8'd1: exp_rd.push_back(m_port1);
            8'd2: exp_rd.push_back(m_addr[7:0]);
            8'd3: exp_rd.push_back({2'b00, m_addr[13:8]});
            8'd4: exp_rd.push_back(8'hFF);
            8'd5: begin
                exp_rd_addr.push_back(m_addr);
                exp_rd.push_back(mem_view(m_addr));
                m_addr = next_addr(m_addr);
            end
            default: ;
        endcase
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        int n;
        bit ok;
        n = 0; ok = 0;
        bus.i_io_wr = 1'b1; bus.i_io_addr = a; bus.i_io_data = d;
        while (!ok && n < 200) begin
            #1;
            if (!bus.o_io_wait) begin ok = 1; model_write(a, d); end
            @(negedge clk);
            n++;
        end
        bus.i_io_wr = 1'b0;
        if (!ok) note_fail("io_write_timeout");
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        int n;
        bit ok;
        logic [7:0] o;
        o = a - BASE;
        n = 0; ok = 0; d = 8'h00;
        bus.i_io_rd = 1'b1; bus.i_io_addr = a;
        while (!ok && n < 200) begin
            #1;
            if (!bus.o_io_wait) begin ok = 1; model_read(a); end
            @(negedge clk);
            n++;
        end
        bus.i_io_rd = 1'b0;
        if (!ok) note_fail("io_read_timeout");
        else if (o <= 8'd5) begin
            n = 0;
            while (!bus.o_io_data_valid && n < 50) begin @(negedge clk); n++; end
            if (!bus.o_io_data_valid) note_fail("io_read_valid_timeout");
            d = bus.o_io_data;
        end
    endtask

    task automatic set_gnt(input logic v);
        @(posedge clk);
        #1 bus.i_mem_gnt = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process and memory responder.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_hrg_port0_valid) begin
                if (exp_p0.size() == 0) note_fail("port0_unexpected_valid");
                else check("port0", bus.o_hrg_port0, exp_p0.pop_front());
            end
            if (bus.o_hrg_port1_valid) begin
                if (exp_p1.size() == 0) note_fail("port1_unexpected_valid");
                else check("port1", bus.o_hrg_port1, exp_p1.pop_front());
            end
            if (bus.o_io_data_valid) begin
                if (exp_rd.size() == 0) note_fail("io_data_unexpected_valid");
                else check("io_data", bus.o_io_data, exp_rd.pop_front());
            end
            if (bus.o_mem_req && bus.i_mem_gnt && bus.o_mem_we) begin
                if (exp_wr.size() == 0) note_fail("mem_write_unexpected");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("mem_wr_addr", bus.o_mem_addr, e.a);
                    check("mem_wr_data", bus.o_mem_wdata, e.d);
                    model_mem[e.a] = e.d;
                end
                mem_log.push_back('{a: bus.o_mem_addr, d: bus.o_mem_wdata});
                ram[bus.o_mem_addr] = bus.o_mem_wdata;
            end
            if (bus.o_mem_req && bus.i_mem_gnt && !bus.o_mem_we) begin
                if (exp_rd_addr.size() == 0) note_fail("mem_read_unexpected");
                else check("mem_rd_addr", bus.o_mem_addr, exp_rd_addr.pop_front());
                bus.i_mem_rdata = ram[bus.o_mem_addr];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 16384; i++) begin model_mem[i] = 8'h00; ram[i] = 8'h00; end
        m_addr = '0; m_port0 = '0; m_port1 = '0;
        bus.i_io_wr = 0; bus.i_io_rd = 0; bus.i_io_addr = 0; bus.i_io_data = 0;
        bus.i_mem_gnt = 0; bus.i_mem_rdata = 0;
        idle(3);
        check("rst_mem_req", bus.o_mem_req, 0);
        check("rst_io_wait", bus.o_io_wait, 0);
        check("rst_valids", {bus.o_io_data_valid, bus.o_hrg_port0_valid, bus.o_hrg_port1_valid}, 0);
        check("rst_values", {bus.o_hrg_port0, bus.o_hrg_port1, bus.o_io_data}, 0);
        check("rst_mem_addr", bus.o_mem_addr, 0);
        rst_n = 1'b1;
        idle(2);

        // Display ports
        io_write(BASE + 8'd0, 8'hA3);
        check("p0_lit_value", bus.o_hrg_port0, 8'hA3);
        check("p0_lit_valid", bus.o_hrg_port0_valid, 1);
        idle(1);
        check("p0_valid_one_cycle", bus.o_hrg_port0_valid, 0);
        io_write(BASE + 8'd1, 8'h5C);
        check("p1_lit_value", bus.o_hrg_port1, 8'h5C);
        check("p1_lit_valid", bus.o_hrg_port1_valid, 1);
        io_read(BASE + 8'd0, d); check("p0_readback", d, 8'hA3);
        io_read(BASE + 8'd1, d); check("p1_readback", d, 8'h5C);
        io_read(BASE + 8'd4, d); check("off4_read_ff", d, 8'hFF);

        // Streaming writes with grant tied high
        set_gnt(1);
        mem_log.delete();
        io_write(BASE + 8'd2, 8'h10);
        io_write(BASE + 8'd3, 8'h00);
        io_write(BASE + 8'd4, 8'h11);
        io_write(BASE + 8'd4, 8'h22);
        io_write(BASE + 8'd4, 8'h33);
        idle(6);
        check("stream_count", mem_log.size(), 3);
        if (mem_log.size() == 3) begin
            check("stream_w0", mem_log[0], {14'h0010, 8'h11});
            check("stream_w1", mem_log[1], {14'h0011, 8'h22});
            check("stream_w2", mem_log[2], {14'h0012, 8'h33});
        end
        io_read(BASE + 8'd2, d); check("addr_lo_13", d, 8'h13);
        io_read(BASE + 8'd3, d); check("addr_hi_00", d, 8'h00);

        // FIFO full back-pressure
        set_gnt(0);
        mem_log.delete();
        for (int i = 0; i < 4; i++) io_write(BASE + 8'd4, 8'h40 + 8'(i));
        fork
            io_write(BASE + 8'd4, 8'h44);
            begin
                idle(3);
                #1 check("wait_when_full", bus.o_io_wait, 1);
                check("no_write_without_gnt", mem_log.size(), 0);
                set_gnt(1);
            end
        join
        idle(8);
        check("full_total_writes", mem_log.size(), 5);

        // Address wrap at ADDR_MAX and above it
        mem_log.delete();
        io_write(BASE + 8'd2, 8'hFF);
        io_write(BASE + 8'd3, 8'h3B);
        io_write(BASE + 8'd4, 8'hAA);
        io_write(BASE + 8'd4, 8'hBB);
        idle(6);
        check("wrap_count", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            check("wrap_addr0", mem_log[0].a, 14'd15359);
            check("wrap_addr1", mem_log[1].a, 14'd0);
        end
        io_read(BASE + 8'd2, d); check("wrap_addr_lo", d, 8'h01);
        mem_log.delete();
        io_write(BASE + 8'd3, 8'hFF);
        io_read(BASE + 8'd3, d); check("addr_hi_masked", d, 8'h3F);
        io_write(BASE + 8'd2, 8'hFF);
        io_write(BASE + 8'd4, 8'h5A);
        idle(6);
        check("top_count", mem_log.size(), 1);
        if (mem_log.size() == 1) check("top_addr", mem_log[0].a, 14'd16383);
        io_read(BASE + 8'd2, d); check("top_wrap_lo", d, 8'h00);
        io_read(BASE + 8'd3, d); check("top_wrap_hi", d, 8'h00);

        // Read after queued writes
        set_gnt(0);
        io_write(BASE + 8'd2, 8'h00);
        io_write(BASE + 8'd3, 8'h01);
        io_write(BASE + 8'd4, 8'h77);
        io_write(BASE + 8'd4, 8'h88);
        io_write(BASE + 8'd2, 8'h00);
        fork
            io_read(BASE + 8'd5, d);
            begin
                idle(3);
                #1 check("wait_read_behind_writes", bus.o_io_wait, 1);
                set_gnt(1);
            end
        join
        check("raw_read0", d, 8'h77);
        io_read(BASE + 8'd5, d); check("raw_read1", d, 8'h88);
        io_read(BASE + 8'd2, d); check("read_post_inc", d, 8'h02);

        // Write and read together: write wins, no read data
        bus.i_io_rd = 1'b1;
        io_write(BASE + 8'd0, 8'h3C);
        bus.i_io_rd = 1'b0;
        // Out-of-range offsets are ignored
        io_write(BASE + 8'd6, 8'h99);
        io_write(8'h00, 8'h99);
        io_read(BASE + 8'd7, d);
        idle(2);
        io_read(BASE + 8'd0, d); check("port0_after_ignored", d, 8'h3C);

        // Reset in the middle of a blocked write burst
        set_gnt(0);
        io_write(BASE + 8'd4, 8'hC1);
        io_write(BASE + 8'd4, 8'hC2);
        io_write(BASE + 8'd4, 8'hC3);
        idle(2);
        check("req_before_reset", bus.o_mem_req, 1);
        #2 rst_n = 1'b0;
        #1 check("req_async_drop", bus.o_mem_req, 0);
        check("wait_async_drop", bus.o_io_wait, 0);
        exp_wr.delete(); exp_p0.delete(); exp_p1.delete(); exp_rd.delete(); exp_rd_addr.delete();
        m_addr = '0; m_port0 = '0; m_port1 = '0;
        idle(2);
        rst_n = 1'b1;
        mem_log.delete();
        set_gnt(1);
        idle(6);
        check("fifo_discarded", mem_log.size(), 0);
        check("req_idle_after_reset", bus.o_mem_req, 0);
        io_read(BASE + 8'd2, d); check("addr_lo_after_reset", d, 8'h00);
        io_read(BASE + 8'd3, d); check("addr_hi_after_reset", d, 8'h00);
        io_read(BASE + 8'd0, d); check("port0_after_reset", d, 8'h00);

        idle(4);
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_rd_drained", exp_rd.size() + exp_p0.size() + exp_p1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
